// File: rtl/program_sequencer.sv
// Purpose: feeds a stored 10-bit program to the processor and generates its timed STEP enable.
// Latency: DATA_OUT is a registered read, valid one CLK after PC changes; STEP every STEP_DIV CLKs in RUN.
// Backpressure: PC advances only when the processor consumes the word (IR_LOAD/EXT_SEL after STEP); PAUSE freezes stepping.
module program_sequencer #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int STEP_DIV = 4
) (
  input  logic          CLK,
  input  logic          CLRn,
  input  logic          START,
  input  logic          ABORT,
  input  logic          PAUSE,
  input  logic [AW-1:0] END_ADDR,
  input  logic          PWR_EN,
  input  logic [AW-1:0] PWR_ADDR,
  input  logic [9:0]    PWR_DATA,
  input  logic          IR_LOAD,
  input  logic          EXT_SEL,
  input  logic          DONE_IN,
  output logic [9:0]    DATA_OUT,
  output logic          STEP,
  output logic [AW-1:0] PC,
  output logic          BUSY,
  output logic          FINISHED
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_HALT} state_t;

  localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

  state_t        state, state_nxt;
  logic [7:0]    div_cnt, div_nxt;
  logic [AW-1:0] pc_nxt;
  logic          last_seen, last_seen_nxt;
  logic          step_d;
  logic          consume;
  logic          at_end;
  logic          prog_open;
  logic [9:0]    mem [DEPTH];

  // The program may only be rewritten while nothing is being fed to the processor.
  assign prog_open = (state == S_IDLE) || (state == S_HALT);
  assign BUSY      = (state == S_RUN) || (state == S_HOLD);
  assign FINISHED  = (state == S_HALT);
  assign STEP      = (state == S_RUN) && (div_cnt == DIV_LAST);
  // The consume window is the cycle after STEP; it survives a pause that began on the STEP cycle.
  assign consume   = step_d && (IR_LOAD || EXT_SEL) && BUSY;
  assign at_end    = (PC == END_ADDR);

  // State, divider, pointer and last-word flag registers.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      state     <= S_IDLE;
      div_cnt   <= 8'd0;
      PC        <= '0;
      last_seen <= 1'b0;
      step_d    <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      PC        <= pc_nxt;
      last_seen <= last_seen_nxt;
      step_d    <= STEP;
    end
  end

  // Next-state, divider and word-pointer logic; ABORT overrides everything else.
  always_comb begin
    state_nxt     = state;
    div_nxt       = div_cnt;
    pc_nxt        = PC;
    last_seen_nxt = last_seen;
    if (ABORT) begin
      state_nxt     = S_IDLE;
      div_nxt       = 8'd0;
      pc_nxt        = '0;
      last_seen_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (START) begin
            state_nxt     = S_RUN;
            div_nxt       = 8'd0;
            pc_nxt        = '0;
            last_seen_nxt = 1'b0;
          end
        end
        S_RUN: begin
          // A STEP already on the wire always completes and wraps the divider, even if PAUSE arrives.
          if (STEP)
            div_nxt = 8'd0;
          else if (!PAUSE)
            div_nxt = div_cnt + 8'd1;
          if (PAUSE)
            state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (!PAUSE)
            state_nxt = S_RUN;
        end
        default: state_nxt = S_IDLE;
      endcase
      if (consume) begin
        if (at_end)
          last_seen_nxt = 1'b1;
        else
          pc_nxt = PC + AW'(1);
      end
      // The final word's own consume counts as seen, so DONE on that same cycle finishes the run.
      if (BUSY && step_d && DONE_IN && (last_seen || (consume && at_end)))
        state_nxt = S_HALT;
    end
  end

  // Program RAM write port; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (PWR_EN && prog_open)
      mem[PWR_ADDR] <= PWR_DATA;
  end

  // Registered read of the word under the pointer, refreshed every cycle.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn)
      DATA_OUT <= 10'd0;
    else
      DATA_OUT <= mem[PC];
  end

endmodule
